// File: rtl/align_pkg.sv
// Shared types and helpers for the RV32IC fetch realigner.
//
// Contents:
//   halfword_t     - one 16-bit instruction parcel
//   INST_C_LEN     - byte length of a compressed instruction
//   INST_LEN       - byte length of a full 32-bit instruction
//   head_kind_e    - what the buffer head currently holds
//   is_compressed  - RVC test on the low parcel of an instruction

package align_pkg;

  typedef logic [15:0] halfword_t;

  localparam int INST_C_LEN = 2;
  localparam int INST_LEN   = 4;

  // Classification of the halfword(s) at the buffer head:
  //   HEAD_EMPTY   - nothing buffered
  //   HEAD_PENDING - low half of a 32-bit instruction, upper half not yet fetched
  //   HEAD_COMP    - a complete 16-bit instruction
  //   HEAD_FULL    - a complete 32-bit instruction
  typedef enum logic [1:0] {
    HEAD_EMPTY,
    HEAD_PENDING,
    HEAD_COMP,
    HEAD_FULL
  } head_kind_e;

  // Any parcel whose two low bits are not 2'b11 is a 16-bit instruction.
  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/halfword_fifo.sv
// Circular halfword store for the fetch realigner.
//
// Accepts 0..PUSH_MAX halfwords per cycle at the tail and releases 0..2
// halfwords per cycle from the head. The two head entries are exposed as
// hw0/hw1 so the consumer can assemble a 32-bit instruction in place.
//
// Ports:
//   clk        - clock
//   reset      - synchronous active-high reset, empties the store
//   clear      - synchronous empty request (redirect), same effect as reset
//   push_cnt   - number of halfwords to append this cycle
//   push_data  - halfwords to append, entry i at bits [16*i +: 16]
//   pop_cnt    - number of halfwords to drop from the head this cycle
//   count      - halfwords currently stored (0..DEPTH)
//   hw0, hw1   - head entry and the entry behind it

module halfword_fifo
  import align_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PUSH_MAX = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH),
  localparam int NW = $clog2(PUSH_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NW-1:0]         push_cnt,
  input  logic [PUSH_MAX*16-1:0] push_data,
  input  logic [1:0]            pop_cnt,
  output logic [CW-1:0]         count,
  output halfword_t             hw0,
  output halfword_t             hw1
);

  halfword_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // Pointer advance modulo DEPTH. Offsets never exceed DEPTH, so a single
  // conditional subtract is enough and DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= DEPTH) begin
      sum = sum - DEPTH;
    end
    return PW'(sum);
  endfunction

  // Storage write: the first push_cnt entries of push_data land in
  // consecutive slots starting at the tail. The producer only pushes when
  // there is room, so these slots never overlap live entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_MAX; i++) begin
      if (!clear && (i < int'(push_cnt))) begin
        mem[wrap_add(wr_ptr, i)] <= push_data[i*16 +: 16];
      end
    end
  end

  // Pointer and occupancy bookkeeping; push and pop may both happen in one
  // cycle and the count moves by their difference.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wrap_add(wr_ptr, int'(push_cnt));
      rd_ptr <= wrap_add(rd_ptr, int'(pop_cnt));
      count  <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  assign hw0 = mem[rd_ptr];
  assign hw1 = mem[wrap_add(rd_ptr, 1)];

endmodule

// File: rtl/fetch_align_buffer.sv
// Instruction realigner between instruction memory and decode (RV32IC).
//
// Fetch words of FETCH_W bits are split into halfwords and buffered; one
// aligned instruction (16- or 32-bit) is presented to decode per handshake,
// together with its PC and a compressed flag. A 32-bit instruction whose
// halves arrive in different fetch words is held until both are present.
// A redirect (flush) empties the buffer and moves the head PC.
//
// Optional build macro:
//   FETCH_ALIGN_ILLEGAL_EN - adds output inst_illegal, raised while the head
//                            instruction is the all-zero RVC parcel.
//
// Ports:
//   clk          - clock
//   reset        - synchronous active-high reset
//   fetch_valid  - fetch word valid
//   fetch_ready  - buffer has room for a full fetch word
//   fetch_pc     - byte address of fetch_data
//   fetch_data   - fetched word, little-endian halfwords
//   flush        - redirect (taken jump/branch)
//   flush_pc     - new head PC on flush (bit 0 ignored)
//   inst_valid   - inst_out/pc_out hold a complete instruction
//   inst_ready   - decode accepts the instruction
//   inst_out     - instruction, compressed ones zero-extended
//   pc_out       - PC of inst_out
//   inst_is_c    - inst_out is a 16-bit instruction
//   stall_pc     - fetch should hold its PC (inverse of fetch_ready)
//   inst_illegal - (FETCH_ALIGN_ILLEGAL_EN only) defined-illegal RVC parcel

module fetch_align_buffer
  import align_pkg::*;
#(
  parameter int          FETCH_W  = 32,
  parameter int          BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [31:0]        fetch_pc,
  input  logic [FETCH_W-1:0] fetch_data,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_out,
  output logic [31:0]        pc_out,
  output logic               inst_is_c,
  output logic               stall_pc
`ifdef FETCH_ALIGN_ILLEGAL_EN
  ,
  output logic               inst_illegal
`endif
);

  localparam int FW_HW  = FETCH_W / 16;
  localparam int SKIP_W = $clog2(FETCH_W / 8) - 1;
  localparam int CW     = $clog2(BUF_HW + 1);
  localparam int NW     = $clog2(FW_HW + 1);

  logic [CW-1:0]     buf_count;
  halfword_t         hw0;
  halfword_t         hw1;
  logic [31:0]       head_pc;
  logic              ready_en;
  logic              first_fetch;
  logic              has_space;
  logic              push_fire;
  logic              pop_fire;
  logic [SKIP_W-1:0] skip;
  logic [NW-1:0]     push_cnt;
  logic [FETCH_W-1:0] push_data;
  logic [1:0]        pop_cnt;
  head_kind_e        head_kind;
  logic              unused_pc_bits;

  // Fetch is held off while reset is asserted and opens on the first clock
  // edge that sees reset low.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // The room test uses the registered count only, ignoring a pop in the same
  // cycle. This keeps fetch_ready free of any path from inst_ready.
  assign has_space   = (BUF_HW - int'(buf_count)) >= FW_HW;
  assign fetch_ready = ready_en & ~reset & has_space;
  assign stall_pc    = ~fetch_ready;

  assign push_fire = fetch_valid & fetch_ready & ~flush;

  // Tracks whether the next accepted word is the first one since reset or a
  // redirect. Only that word can start in the middle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      first_fetch <= 1'b1;
    end else if (push_fire) begin
      first_fetch <= 1'b0;
    end
  end

  // Leading halfwords below the wanted PC are dropped. For the first word
  // after a redirect the wanted PC is head_pc; memory may report either the
  // word-aligned address or head_pc itself, and taking the offset from
  // head_pc is correct in both cases. Later words are word-aligned.
  assign skip      = first_fetch ? head_pc[SKIP_W:1] : fetch_pc[SKIP_W:1];
  assign push_cnt  = push_fire ? (NW'(FW_HW) - NW'(skip)) : '0;
  assign push_data = fetch_data >> {skip, 4'b0000};

  halfword_fifo #(
    .DEPTH    (BUF_HW),
    .PUSH_MAX (FW_HW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .count     (buf_count),
    .hw0       (hw0),
    .hw1       (hw1)
  );

  // Classify the head: a compressed parcel is complete on its own, a 32-bit
  // one needs its upper parcel to be buffered as well.
  always_comb begin
    head_kind = HEAD_EMPTY;
    if (buf_count != '0) begin
      if (is_compressed(hw0)) begin
        head_kind = HEAD_COMP;
      end else if (buf_count >= CW'(2)) begin
        head_kind = HEAD_FULL;
      end else begin
        head_kind = HEAD_PENDING;
      end
    end
  end

  // Instruction assembly straight from the buffer head. Outputs only change
  // on a pop, a flush or a reset, so they hold steady under backpressure.
  always_comb begin
    inst_valid = 1'b0;
    inst_is_c  = 1'b0;
    inst_out   = '0;
    case (head_kind)
      HEAD_COMP: begin
        inst_valid = 1'b1;
        inst_is_c  = 1'b1;
        inst_out   = {16'h0000, hw0};
      end
      HEAD_FULL: begin
        inst_valid = 1'b1;
        inst_out   = {hw1, hw0};
      end
      default: begin
      end
    endcase
  end

  assign pc_out = head_pc;

  // A flush discards any same-cycle pop along with the buffered contents.
  assign pop_fire = inst_valid & inst_ready & ~flush;
  assign pop_cnt  = pop_fire ? (inst_is_c ? 2'd1 : 2'd2) : 2'd0;

  // Head PC follows the consumed instructions; a redirect overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_pc <= RESET_PC;
    end else if (flush) begin
      head_pc <= {flush_pc[31:1], 1'b0};
    end else if (pop_fire) begin
      head_pc <= head_pc + (inst_is_c ? 32'(INST_C_LEN) : 32'(INST_LEN));
    end
  end

`ifdef FETCH_ALIGN_ILLEGAL_EN
  // The all-zero RVC parcel is architecturally illegal; it is still
  // delivered and consumed like any other compressed instruction.
  assign inst_illegal = inst_valid & inst_is_c & (hw0 == 16'h0000);
`endif

  // Address bits that carry no information for the realigner.
  assign unused_pc_bits = ^{fetch_pc[31:SKIP_W+1], fetch_pc[0], flush_pc[0]};

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Self-checking bench for fetch_align_buffer (FETCH_W=32, BUF_HW=4).
// Expected instructions are queued when fetch words are driven and compared
// when the DUT hands them to decode. Inputs change and outputs are sampled
// on the falling clock edge.

module tb_fetch_align_buffer;

  localparam int          FETCH_W  = 32;
  localparam int          BUF_HW   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic               fetch_valid;
  logic               fetch_ready;
  logic [31:0]        fetch_pc;
  logic [FETCH_W-1:0] fetch_data;
  logic               flush;
  logic [31:0]        flush_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic [31:0]        inst_out;
  logic [31:0]        pc_out;
  logic               inst_is_c;
  logic               stall_pc;
`ifdef FETCH_ALIGN_ILLEGAL_EN
  logic               inst_illegal;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  fetch_align_buffer #(
    .FETCH_W  (FETCH_W),
    .BUF_HW   (BUF_HW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_pc     (fetch_pc),
    .fetch_data   (fetch_data),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .inst_is_c    (inst_is_c),
    .stall_pc     (stall_pc)
`ifdef FETCH_ALIGN_ILLEGAL_EN
    ,
    .inst_illegal (inst_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Hard stop in case something never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_fetch(input logic [31:0] pc, input logic [31:0] data);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_data  = data;
  endtask

  // Called on a falling edge; leaves the bench on the next falling edge.
  task automatic apply_flush(input logic [31:0] pc);
    fetch_valid = 1'b0;
    flush       = 1'b1;
    flush_pc    = pc;
    @(negedge clk);
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    fetch_data  = '0;
    flush       = 1'b0;
    flush_pc    = '0;
    inst_ready  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_fetch_ready: got %b expected 0", fetch_ready);
    end
    checks++;
    if (stall_pc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_stall_pc: got %b expected 1", stall_pc);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid);
    end
    checks++;
    if (pc_out !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL reset_pc_out: got %h expected %h", pc_out, RESET_PC);
    end
    checks++;
    if ({inst_out, inst_is_c} !== 33'h0) begin
      errors++;
      $display("[TB] FAIL reset_inst: got inst=%h c=%b expected 0/0", inst_out, inst_is_c);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", fetch_ready);
    end
  endtask

  task automatic test_aligned_mix();
    exp_t e;
    inst_ready = 1'b1;
    apply_flush(32'h0);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (inst_valid && inst_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL mix_extra: got inst=%h pc=%h expected none", inst_out, pc_out);
        end else begin
          e = sb.pop_front();
          if ({inst_out, pc_out, inst_is_c} !== {e.inst, e.pc, e.is_c}) begin
            errors++;
            $display("[TB] FAIL mix_inst: got inst=%h pc=%h c=%b expected inst=%h pc=%h c=%b",
                     inst_out, pc_out, inst_is_c, e.inst, e.pc, e.is_c);
          end
        end
      end
      fetch_valid = 1'b0;
      if (cyc == 0) begin
        drive_fetch(32'h0, 32'h4501_0513);
        sb.push_back({32'h4501_0513, 32'h0, 1'b0});
      end
      if (cyc == 1) begin
        drive_fetch(32'h4, 32'h0000_0001);
        sb.push_back({32'h0000_0001, 32'h4, 1'b1});
        sb.push_back({32'h0000_0000, 32'h6, 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL mix_missing: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_straddle();
    exp_t e;
    inst_ready = 1'b1;
    apply_flush(32'h0);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 2) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL straddle_pending: got inst_valid=%b expected 0", inst_valid);
        end
      end
      if (inst_valid && inst_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL straddle_extra: got inst=%h pc=%h expected none", inst_out, pc_out);
        end else begin
          e = sb.pop_front();
          if ({inst_out, pc_out, inst_is_c} !== {e.inst, e.pc, e.is_c}) begin
            errors++;
            $display("[TB] FAIL straddle_inst: got inst=%h pc=%h c=%b expected inst=%h pc=%h c=%b",
                     inst_out, pc_out, inst_is_c, e.inst, e.pc, e.is_c);
          end
        end
      end
      fetch_valid = 1'b0;
      if (cyc == 0) begin
        drive_fetch(32'h0, 32'h0513_4505);
        sb.push_back({32'h0000_4505, 32'h0, 1'b1});
      end
      if (cyc == 2) begin
        drive_fetch(32'h4, 32'hABCD_0001);
        sb.push_back({32'h0001_0513, 32'h2, 1'b0});
        sb.push_back({32'h0000_ABCD, 32'h6, 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL straddle_missing: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_misaligned_entry();
    exp_t e;
    inst_ready = 1'b1;
    apply_flush(32'h102);
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (inst_valid && inst_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL misalign_extra: got inst=%h pc=%h expected none", inst_out, pc_out);
        end else begin
          e = sb.pop_front();
          if ({inst_out, pc_out, inst_is_c} !== {e.inst, e.pc, e.is_c}) begin
            errors++;
            $display("[TB] FAIL misalign_inst: got inst=%h pc=%h c=%b expected inst=%h pc=%h c=%b",
                     inst_out, pc_out, inst_is_c, e.inst, e.pc, e.is_c);
          end
        end
      end
      fetch_valid = 1'b0;
      if (cyc == 0) begin
        drive_fetch(32'h100, 32'h1234_8082);
        sb.push_back({32'h0000_1234, 32'h102, 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0 || pc_out !== 32'h104) begin
      errors++;
      $display("[TB] FAIL misalign_end: got outstanding=%0d pc=%h expected 0 and 00000104",
               sb.size(), pc_out);
      sb.delete();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    inst_ready = 1'b0;
    apply_flush(32'h0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc >= 5) inst_ready = 1'b1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if ({fetch_ready, stall_pc, inst_valid, inst_out, pc_out, inst_is_c} !==
            {1'b0, 1'b1, 1'b1, 32'h00A0_0513, 32'h0, 1'b0}) begin
          errors++;
          $display("[TB] FAIL bp_hold: got rdy=%b stall=%b v=%b inst=%h pc=%h c=%b expected 0 1 1 00a00513 00000000 0",
                   fetch_ready, stall_pc, inst_valid, inst_out, pc_out, inst_is_c);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (fetch_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL bp_reopen: got fetch_ready=%b expected 1", fetch_ready);
        end
      end
      if (inst_valid && inst_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_extra: got inst=%h pc=%h expected none", inst_out, pc_out);
        end else begin
          e = sb.pop_front();
          if ({inst_out, pc_out, inst_is_c} !== {e.inst, e.pc, e.is_c}) begin
            errors++;
            $display("[TB] FAIL bp_inst: got inst=%h pc=%h c=%b expected inst=%h pc=%h c=%b",
                     inst_out, pc_out, inst_is_c, e.inst, e.pc, e.is_c);
          end
        end
      end
      fetch_valid = 1'b0;
      if (cyc == 0) begin
        drive_fetch(32'h0, 32'h00A0_0513);
        sb.push_back({32'h00A0_0513, 32'h0, 1'b0});
      end
      if (cyc == 1) begin
        drive_fetch(32'h4, 32'h00B0_0593);
        sb.push_back({32'h00B0_0593, 32'h4, 1'b0});
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_missing: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_flush_midstream();
    inst_ready = 1'b0;
    apply_flush(32'h40);
    drive_fetch(32'h40, 32'h00A0_0513);
    @(negedge clk);
    drive_fetch(32'h44, 32'h00B0_0593);
    flush      = 1'b1;
    flush_pc   = 32'h200;
    inst_ready = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    fetch_valid = 1'b0;
    checks++;
    if ({inst_valid, pc_out, fetch_ready} !== {1'b0, 32'h200, 1'b1}) begin
      errors++;
      $display("[TB] FAIL flush_next: got v=%b pc=%h rdy=%b expected 0 00000200 1",
               inst_valid, pc_out, fetch_ready);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_dropped: got inst_valid=%b inst=%h expected 0", inst_valid, inst_out);
      end
    end
    apply_flush(32'h301);
    checks++;
    if (pc_out !== 32'h300) begin
      errors++;
      $display("[TB] FAIL flush_bit0: got pc=%h expected 00000300", pc_out);
    end
  endtask

  task automatic test_random_stream();
    exp_t        e;
    logic [15:0] hq[$];
    logic [31:0] mpc;
    logic [31:0] d;
    int          k;
    int          cyc;
    apply_flush(32'h1000);
    mpc = 32'h1000;
    k   = 0;
    cyc = 0;
    while ((k < 40 || sb.size() != 0) && cyc < 600) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if (inst_valid && inst_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_extra: got inst=%h pc=%h expected none", inst_out, pc_out);
        end else begin
          e = sb.pop_front();
          if ({inst_out, pc_out, inst_is_c} !== {e.inst, e.pc, e.is_c}) begin
            errors++;
            $display("[TB] FAIL rand_inst: got inst=%h pc=%h c=%b expected inst=%h pc=%h c=%b",
                     inst_out, pc_out, inst_is_c, e.inst, e.pc, e.is_c);
          end
        end
      end
      fetch_valid = 1'b0;
      if (k < 40 && fetch_ready && ($urandom_range(0, 4) != 0)) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d[1:0] = 2'b11;
        if ($urandom_range(0, 1) == 1) d[17:16] = 2'b11;
        drive_fetch(32'h1000 + 32'(4 * k), d);
        k++;
        hq.push_back(d[15:0]);
        hq.push_back(d[31:16]);
        while (hq.size() > 0) begin
          if (hq[0][1:0] != 2'b11) begin
            sb.push_back({16'h0000, hq[0], mpc, 1'b1});
            mpc = mpc + 32'd2;
            void'(hq.pop_front());
          end else if (hq.size() >= 2) begin
            sb.push_back({hq[1], hq[0], mpc, 1'b0});
            mpc = mpc + 32'd4;
            void'(hq.pop_front());
            void'(hq.pop_front());
          end else begin
            break;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    fetch_valid = 1'b0;
    checks++;
    if (sb.size() != 0 || k != 40) begin
      errors++;
      $display("[TB] FAIL rand_timeout: got outstanding=%0d fetched=%0d expected 0 and 40", sb.size(), k);
      sb.delete();
    end
    inst_ready = 1'b0;
    apply_flush(32'h0);
  endtask

  task automatic test_reset_with_count();
    inst_ready = 1'b0;
    apply_flush(32'h2);
    drive_fetch(32'h0, 32'h0001_0513);
    @(negedge clk);
    drive_fetch(32'h4, 32'h0002_0003);
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++;
    if ({fetch_ready, stall_pc, inst_valid, inst_out, pc_out} !==
        {1'b0, 1'b1, 1'b1, 32'h0000_0001, 32'h2}) begin
      errors++;
      $display("[TB] FAIL count3_state: got rdy=%b stall=%b v=%b inst=%h pc=%h expected 0 1 1 00000001 00000002",
               fetch_ready, stall_pc, inst_valid, inst_out, pc_out);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({inst_valid, pc_out, fetch_ready} !== {1'b0, RESET_PC, 1'b0}) begin
      errors++;
      $display("[TB] FAIL count3_reset: got v=%b pc=%h rdy=%b expected 0 %h 0",
               inst_valid, pc_out, fetch_ready, RESET_PC);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({inst_valid, fetch_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL count3_release: got v=%b rdy=%b expected 0 1", inst_valid, fetch_ready);
    end
  endtask

`ifdef FETCH_ALIGN_ILLEGAL_EN
  task automatic test_illegal();
    inst_ready = 1'b0;
    apply_flush(32'h0);
    drive_fetch(32'h0, 32'h0000_0000);
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++;
    if ({inst_illegal, inst_valid, inst_is_c, pc_out} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL illegal_first: got ill=%b v=%b c=%b pc=%h expected 1 1 1 00000000",
               inst_illegal, inst_valid, inst_is_c, pc_out);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({inst_illegal, pc_out} !== {1'b1, 32'h2}) begin
      errors++;
      $display("[TB] FAIL illegal_second: got ill=%b pc=%h expected 1 00000002", inst_illegal, pc_out);
    end
    @(negedge clk);
    inst_ready = 1'b0;
    drive_fetch(32'h4, 32'h0000_0001);
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++;
    if ({inst_illegal, inst_valid, inst_out} !== {1'b0, 1'b1, 32'h0000_0001}) begin
      errors++;
      $display("[TB] FAIL illegal_legal_c: got ill=%b v=%b inst=%h expected 0 1 00000001",
               inst_illegal, inst_valid, inst_out);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++;
    if ({inst_illegal, pc_out} !== {1'b1, 32'h6}) begin
      errors++;
      $display("[TB] FAIL illegal_after_pop: got ill=%b pc=%h expected 1 00000006", inst_illegal, pc_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_aligned_mix();
    test_straddle();
    test_misaligned_entry();
    test_backpressure();
    test_flush_midstream();
    test_random_stream();
    test_reset_with_count();
`ifdef FETCH_ALIGN_ILLEGAL_EN
    test_illegal();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Parametrised instruction realigner between instruction memory and decode for RV32IC.
- Accepts fetch words of FETCH_W bits at any halfword-aligned PC.
- Buffers halfwords and reassembles 32-bit instructions that straddle fetch words.
- Emits one aligned instruction per handshake with its PC and a compressed flag; supports redirect flush on jump/branch.

Parameters:
FETCH_W, 32, fetch word width in bits; legal values 32 or 64.
BUF_HW, 4, halfword buffer depth; must be at least 2*FETCH_W/16.
RESET_PC, 32'h0000_0000, PC of the first instruction after reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fetch_valid  in  1  fetch word valid
fetch_ready  out  1  buffer can accept a full fetch word
fetch_pc  in  32  byte address of fetch_data; bit 0 is always 0
fetch_data  in  FETCH_W  fetched word, little-endian halfwords
flush  in  1  redirect (jump/branch taken)
flush_pc  in  32  new head PC on flush
inst_valid  out  1  inst_out/pc_out hold a complete instruction
inst_ready  in  1  decode accepts the instruction
inst_out  out  32  instruction; compressed instructions are zero-extended to {16'h0, hw}
pc_out  out  32  PC of inst_out
inst_is_c  out  1  inst_out is a 16-bit instruction
stall_pc  out  1  equals ~fetch_ready; holds the fetch PC

Behaviour:
- Reset (synchronous, priority over everything):
  - count=0, head_pc=RESET_PC, buffer contents don't-care.
  - inst_valid=0, inst_out=0, inst_is_c=0, pc_out=RESET_PC.
  - fetch_ready=1 after the first clock edge with reset low; fetch_ready=0 while reset is high.
- State: circular halfword buffer (rd_ptr, wr_ptr, count 0..BUF_HW) and head_pc.
- Push on fetch_valid & fetch_ready:
  - Skip leading halfwords below the PC: skip = fetch_pc[log2(FETCH_W/8)-1:1].
  - Write the remaining FETCH_W/16 - skip halfwords in ascending order.
  - The first fetch after reset or flush may carry a misaligned PC; later fetches are aligned.
- fetch_ready = (BUF_HW - count) >= FETCH_W/16, computed from registered count before any same-cycle pop (conservative).
- Output (combinational from buffer head):
  - count>=1 and hw0[1:0]!=2'b11: compressed; inst_out={16'h0,hw0}, inst_is_c=1, inst_valid=1.
  - hw0[1:0]==2'b11 and count>=2: 32-bit; inst_out={hw1,hw0}, inst_is_c=0, inst_valid=1.
  - hw0[1:0]==2'b11 and count==1: straddle pending; inst_valid=0 and hw0 is retained until the next push.
  - count==0: inst_valid=0.
  - pc_out=head_pc at all times.
- Pop on inst_valid & inst_ready:
  - Remove 1 halfword (compressed) or 2 halfwords (32-bit).
  - head_pc += 2 or 4; 32-bit wrap-around is ignored.
  - inst_out, pc_out and inst_is_c must stay stable while inst_valid & ~inst_ready.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped. Pointers wrap modulo BUF_HW.
- Flush (priority over push/pop, below reset):
  - Next cycle: count=0, head_pc=flush_pc; same-cycle fetch and pop are discarded.
  - inst_valid=0 in the cycle after flush.
  - flush_pc[0] is ignored (treated as 0).
- Latency: fetch accepted at edge N gives inst_valid at cycle N+1 if a complete instruction is present. No combinational path from fetch_* to inst_*.

Optional Feature:
- Macro: FETCH_ALIGN_ILLEGAL_EN.
- Defined:
  - Adds output port inst_illegal (1 bit).
  - inst_illegal=1 when inst_valid & inst_is_c & hw0==16'h0000 (defined-illegal RVC encoding); reset value 0.
  - The instruction is still delivered and popped normally.
- Undefined: the port is absent and no detection logic is generated.

Decomposition:
- Package align_pkg:
  - typedef halfword_t (logic [15:0]).
  - Constant INST_C_LEN=2, INST_LEN=4.
  - Function is_compressed(halfword_t) returning hw[1:0]!=2'b11.
- Sub-module halfword_fifo:
  - Circular store, pointers and count.
  - Variable push count (0..FETCH_W/16) and pop count (0..2).
  - Peek of the two head entries and a synchronous clear.
- Top level holds the push-skip logic, instruction decode/assembly, head_pc and flush control.

Test Plan:
- Aligned mix, FETCH_W=32: fetch pc=0x0 data=0x4501_0513, then pc=0x4 data=0x0000_0001 -> first instruction 0x4501_0513 at pc 0x0 (inst_is_c=0, since low halfword 0x0513 ends in 2'b11); the pc 0x4 word yields compressed hw 0x0001 at pc 0x4 (inst_out=0x0000_0001, inst_is_c=1), then the remaining halfword 0x0000 at pc 0x6.
- Straddle: fetch pc=0x0 data=0x0513_4505 -> inst 0x0000_4505 at pc 0x0 (C); then inst_valid=0 while hw 0x0513 waits; fetch pc=0x4 data=0xABCD_0001 -> inst 0x0001_0513 at pc 0x2.
- Misaligned entry after flush: flush with flush_pc=0x102, then fetch pc=0x100 data=0x1234_8082 -> only hw 0x1234 is kept (0x8082 discarded); since 0x1234 is compressed, inst 0x0000_1234 at pc 0x102.
- Backpressure: hold inst_ready=0 with BUF_HW=4 and two 32-bit fetches -> count=4, fetch_ready=0 and stall_pc=1; outputs stay stable.
- Flush mid-stream with fetch_valid=1 in the same cycle -> fetch word dropped; next cycle inst_valid=0 and pc_out=flush_pc.
- Reset asserted with count=3 -> next cycle inst_valid=0 and pc_out=RESET_PC; with FETCH_ALIGN_ILLEGAL_EN defined, fetch data 0x0000_0000 yields inst_illegal=1 at pc 0x0.
